// File: rtl/dqdbp_link_sched_pkg.sv
// Shared types and sizes for the dqd backward-pass link sequencer.
// Optional cycle profiling in the top is enabled by DQDBP_PROFILE_EN.
package dqdbp_link_sched_pkg;

  localparam int NUM_LINKS = 7;
  localparam int LINK_W    = 3;
  localparam int NUM_LANES = 6;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN
  } state_e;

  typedef enum logic [2:0] {
    AX = 3'd0,
    AY = 3'd1,
    AZ = 3'd2,
    LX = 3'd3,
    LY = 3'd4,
    LZ = 3'd5
  } lane_e;

endpackage

// File: rtl/dqdbp_vec_buf.sv
// Per-link df/dqd vector store: 8 entries, entry 0 is the base link
// and always reads as zero; two comb read ports, load and writeback.
module dqdbp_vec_buf
  import dqdbp_link_sched_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [LINK_W-1:0]                 ra_addr,
  output logic [NUM_LANES-1:0][WIDTH-1:0]   ra_data,
  input  logic [LINK_W-1:0]                 rb_addr,
  output logic [NUM_LANES-1:0][WIDTH-1:0]   rb_data,
  input  logic                              ld_we,
  input  logic [LINK_W-1:0]                 ld_addr,
  input  logic [NUM_LANES-1:0][WIDTH-1:0]   ld_data,
  input  logic                              wb_we,
  input  logic [LINK_W-1:0]                 wb_addr,
  input  logic [NUM_LANES-1:0][WIDTH-1:0]   wb_data
);

  typedef logic [NUM_LANES-1:0][WIDTH-1:0] vec_t;

  vec_t mem_q [NUM_LINKS+1];
  vec_t mem_d [NUM_LINKS+1];

  always_comb begin
    mem_d = mem_q;
    if (wb_we) mem_d[wb_addr] = wb_data;
    if (ld_we) mem_d[ld_addr] = ld_data;
    mem_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NUM_LINKS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign ra_data = mem_q[ra_addr];
  assign rb_data = mem_q[rb_addr];

endmodule

// File: rtl/dqdbp_link_sched.sv
// Sequencer that walks links 7..1 through the dqd backward-pass stage.
// DQDBP_PROFILE_EN adds cycles_out, a RUN/DRAIN cycle counter.
module dqdbp_link_sched
  import dqdbp_link_sched_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int DECIMAL_BITS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LINK_W-1:0] in_link,
  input  logic [WIDTH-1:0]  in_sinq,
  input  logic [WIDTH-1:0]  in_cosq,
  input  logic [WIDTH-1:0]  in_f_AX,
  input  logic [WIDTH-1:0]  in_f_AY,
  input  logic [WIDTH-1:0]  in_f_AZ,
  input  logic [WIDTH-1:0]  in_f_LX,
  input  logic [WIDTH-1:0]  in_f_LY,
  input  logic [WIDTH-1:0]  in_f_LZ,
  output logic [LINK_W-1:0] stg_link,
  output logic [WIDTH-1:0]  stg_sinq,
  output logic [WIDTH-1:0]  stg_cosq,
  output logic [WIDTH-1:0]  stg_curr_AX,
  output logic [WIDTH-1:0]  stg_curr_AY,
  output logic [WIDTH-1:0]  stg_curr_AZ,
  output logic [WIDTH-1:0]  stg_curr_LX,
  output logic [WIDTH-1:0]  stg_curr_LY,
  output logic [WIDTH-1:0]  stg_curr_LZ,
  output logic [WIDTH-1:0]  stg_prev_AX,
  output logic [WIDTH-1:0]  stg_prev_AY,
  output logic [WIDTH-1:0]  stg_prev_AZ,
  output logic [WIDTH-1:0]  stg_prev_LX,
  output logic [WIDTH-1:0]  stg_prev_LY,
  output logic [WIDTH-1:0]  stg_prev_LZ,
  output logic              stg_minv,
  input  logic [WIDTH-1:0]  stg_dtau,
  input  logic [WIDTH-1:0]  stg_upd_AX,
  input  logic [WIDTH-1:0]  stg_upd_AY,
  input  logic [WIDTH-1:0]  stg_upd_AZ,
  input  logic [WIDTH-1:0]  stg_upd_LX,
  input  logic [WIDTH-1:0]  stg_upd_LY,
  input  logic [WIDTH-1:0]  stg_upd_LZ,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LINK_W-1:0] out_link,
  output logic [WIDTH-1:0]  out_dtau,
  output logic              done,
  output logic              load_err
`ifdef DQDBP_PROFILE_EN
  ,
  output logic [15:0]       cycles_out
`endif
);

  typedef logic [NUM_LANES-1:0][WIDTH-1:0] vec_t;

  localparam logic [LINK_W-1:0] FIRST = LINK_W'(1);
  localparam logic [LINK_W-1:0] LAST  = LINK_W'(NUM_LINKS);

  if (DECIMAL_BITS >= WIDTH) begin : g_bad_q
    $error("DECIMAL_BITS must be below WIDTH");
  end

  state_e            state_q, state_d;
  logic [LINK_W-1:0] k_q, k_d;
  logic [LINK_W-1:0] nxt_q, nxt_d;
  logic              ov_q, ov_d;
  logic [LINK_W-1:0] olink_q, olink_d;
  logic [WIDTH-1:0]  odtau_q, odtau_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [WIDTH-1:0]  sin_q [NUM_LINKS+1];
  logic [WIDTH-1:0]  sin_d [NUM_LINKS+1];
  logic [WIDTH-1:0]  cos_q [NUM_LINKS+1];
  logic [WIDTH-1:0]  cos_d [NUM_LINKS+1];

  logic ld_we, wb_we, advance;
  vec_t ld_vec, upd_vec, cur_vec, prv_vec;

  assign ld_vec  = {in_f_LZ, in_f_LY, in_f_LX,
                    in_f_AZ, in_f_AY, in_f_AX};
  assign upd_vec = {stg_upd_LZ, stg_upd_LY, stg_upd_LX,
                    stg_upd_AZ, stg_upd_AY, stg_upd_AX};

  dqdbp_vec_buf #(.WIDTH(WIDTH)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra_addr (k_q),
    .ra_data (cur_vec),
    .rb_addr (k_q - 1'b1),
    .rb_data (prv_vec),
    .ld_we   (ld_we),
    .ld_addr (in_link),
    .ld_data (ld_vec),
    .wb_we   (wb_we),
    .wb_addr (k_q - 1'b1),
    .wb_data (upd_vec)
  );

  // A held output beat freezes the walk, so a parent is never updated twice.
  assign advance = !ov_q || out_ready;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    nxt_d   = nxt_q;
    ov_d    = ov_q;
    olink_d = olink_q;
    odtau_d = odtau_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    sin_d   = sin_q;
    cos_d   = cos_q;
    ld_we   = 1'b0;
    wb_we   = 1'b0;
    unique case (state_q)
      IDLE, LOAD: begin
        if (in_valid) begin
          if (in_link == nxt_q) begin
            ld_we          = 1'b1;
            sin_d[in_link] = in_sinq;
            cos_d[in_link] = in_cosq;
            if (nxt_q == LAST) begin
              state_d = RUN;
              k_d     = LAST;
              nxt_d   = FIRST;
            end else begin
              state_d = LOAD;
              nxt_d   = nxt_q + 1'b1;
            end
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
            nxt_d   = FIRST;
          end
        end
      end
      RUN: begin
        if (advance) begin
          ov_d    = 1'b1;
          olink_d = k_q;
          odtau_d = stg_dtau;
          if (k_q > FIRST) begin
            wb_we = 1'b1;
            k_d   = k_q - 1'b1;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= LAST;
      nxt_q   <= FIRST;
      ov_q    <= 1'b0;
      olink_q <= '0;
      odtau_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i <= NUM_LINKS; i++) begin
        sin_q[i] <= '0;
        cos_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      nxt_q   <= nxt_d;
      ov_q    <= ov_d;
      olink_q <= olink_d;
      odtau_q <= odtau_d;
      done_q  <= done_d;
      err_q   <= err_d;
      sin_q   <= sin_d;
      cos_q   <= cos_d;
    end
  end

  assign in_ready    = (state_q == IDLE) || (state_q == LOAD);
  assign stg_link    = (state_q == RUN) ? k_q : '0;
  assign stg_sinq    = sin_q[k_q];
  assign stg_cosq    = cos_q[k_q];
  assign stg_curr_AX = cur_vec[AX];
  assign stg_curr_AY = cur_vec[AY];
  assign stg_curr_AZ = cur_vec[AZ];
  assign stg_curr_LX = cur_vec[LX];
  assign stg_curr_LY = cur_vec[LY];
  assign stg_curr_LZ = cur_vec[LZ];
  assign stg_prev_AX = prv_vec[AX];
  assign stg_prev_AY = prv_vec[AY];
  assign stg_prev_AZ = prv_vec[AZ];
  assign stg_prev_LX = prv_vec[LX];
  assign stg_prev_LY = prv_vec[LY];
  assign stg_prev_LZ = prv_vec[LZ];
  assign stg_minv    = 1'b0;
  assign out_valid   = ov_q;
  assign out_link    = olink_q;
  assign out_dtau    = odtau_q;
  assign done        = done_q;
  assign load_err    = err_q;

`ifdef DQDBP_PROFILE_EN
  logic [15:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (state_d == RUN && state_q != RUN) begin
      cyc_d = '0;
    end else if ((state_q == RUN || state_q == DRAIN)
                 && cyc_q != 16'hFFFF) begin
      cyc_d = cyc_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc_q <= '0;
    else        cyc_q <= cyc_d;
  end

  assign cycles_out = cyc_q;
`endif

endmodule

// File: tb/tb_dqdbp_link_sched.sv
// Scoreboard bench for dqdbp_link_sched with a simple stage model:
// dtau = curr AZ, updated parent = prev + curr per lane.
module tb_dqdbp_link_sched;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         in_valid, in_ready;
  logic [2:0]   in_link;
  logic [W-1:0] in_sinq, in_cosq;
  logic [W-1:0] in_f_AX, in_f_AY, in_f_AZ, in_f_LX, in_f_LY, in_f_LZ;
  logic [2:0]   stg_link;
  logic [W-1:0] stg_sinq, stg_cosq;
  logic [W-1:0] stg_curr_AX, stg_curr_AY, stg_curr_AZ;
  logic [W-1:0] stg_curr_LX, stg_curr_LY, stg_curr_LZ;
  logic [W-1:0] stg_prev_AX, stg_prev_AY, stg_prev_AZ;
  logic [W-1:0] stg_prev_LX, stg_prev_LY, stg_prev_LZ;
  logic         stg_minv;
  logic [W-1:0] stg_dtau;
  logic [W-1:0] stg_upd_AX, stg_upd_AY, stg_upd_AZ;
  logic [W-1:0] stg_upd_LX, stg_upd_LY, stg_upd_LZ;
  logic         out_valid, out_ready;
  logic [2:0]   out_link;
  logic [W-1:0] out_dtau;
  logic         done, load_err;
`ifdef DQDBP_PROFILE_EN
  logic [15:0]  cycles_out;
`endif

  assign stg_dtau   = stg_curr_AZ;
  assign stg_upd_AX = stg_prev_AX + stg_curr_AX;
  assign stg_upd_AY = stg_prev_AY + stg_curr_AY;
  assign stg_upd_AZ = stg_prev_AZ + stg_curr_AZ;
  assign stg_upd_LX = stg_prev_LX + stg_curr_LX;
  assign stg_upd_LY = stg_prev_LY + stg_curr_LY;
  assign stg_upd_LZ = stg_prev_LZ + stg_curr_LZ;

  dqdbp_link_sched dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_link(in_link),
    .in_sinq(in_sinq), .in_cosq(in_cosq),
    .in_f_AX(in_f_AX), .in_f_AY(in_f_AY), .in_f_AZ(in_f_AZ),
    .in_f_LX(in_f_LX), .in_f_LY(in_f_LY), .in_f_LZ(in_f_LZ),
    .stg_link(stg_link), .stg_sinq(stg_sinq), .stg_cosq(stg_cosq),
    .stg_curr_AX(stg_curr_AX), .stg_curr_AY(stg_curr_AY),
    .stg_curr_AZ(stg_curr_AZ), .stg_curr_LX(stg_curr_LX),
    .stg_curr_LY(stg_curr_LY), .stg_curr_LZ(stg_curr_LZ),
    .stg_prev_AX(stg_prev_AX), .stg_prev_AY(stg_prev_AY),
    .stg_prev_AZ(stg_prev_AZ), .stg_prev_LX(stg_prev_LX),
    .stg_prev_LY(stg_prev_LY), .stg_prev_LZ(stg_prev_LZ),
    .stg_minv(stg_minv), .stg_dtau(stg_dtau),
    .stg_upd_AX(stg_upd_AX), .stg_upd_AY(stg_upd_AY),
    .stg_upd_AZ(stg_upd_AZ), .stg_upd_LX(stg_upd_LX),
    .stg_upd_LY(stg_upd_LY), .stg_upd_LZ(stg_upd_LZ),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_link(out_link), .out_dtau(out_dtau),
    .done(done), .load_err(load_err)
`ifdef DQDBP_PROFILE_EN
    , .cycles_out(cycles_out)
`endif
  );

  localparam logic [31:0] EXP [7] = '{
    32'h0007_0000, 32'h000D_0000, 32'h0012_0000, 32'h0016_0000,
    32'h0019_0000, 32'h001B_0000, 32'h001C_0000
  };

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = -100;
  int done_cnt = 0;
  logic [34:0] exp_q [$];
  logic [34:0] e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexp_out: got link %0d dtau %0h want none",
                 out_link, out_dtau);
      end else begin
        e = exp_q.pop_front();
        chk("out_link", 32'(out_link), 32'(e[34:32]));
        chk("out_dtau", out_dtau, e[31:0]);
        if (out_link == 3'd1) acc_cyc = cyc;
      end
    end
    if (rst_n && done) begin
      done_cnt++;
      chk("done_timing", 32'(cyc), 32'(acc_cyc + 1));
    end
  end

  task automatic push_seq();
    for (int i = 0; i < 7; i++) exp_q.push_back({3'(7 - i), EXP[i]});
  endtask

  task automatic load(input int bad_pos, input logic [2:0] bad_link);
    for (int n = 1; n <= 7; n++) begin
      in_valid = 1'b1;
      in_link  = (n == bad_pos) ? bad_link : 3'(n);
      in_f_AZ  = 32'(n) << 16;
      in_sinq  = 32'(n * 3);
      in_cosq  = 32'(n * 5);
      chk("in_ready_load", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      if (n == bad_pos) begin
        chk("load_err", 32'(load_err), 32'd1);
        chk("in_ready_err", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        return;
      end
      chk("no_load_err", 32'(load_err), 32'd0);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done want done");
    end else begin
      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      chk("done_pulse", 32'(done), 32'd0);
      chk("idle_out_valid", 32'(out_valid), 32'd0);
      chk("idle_in_ready", 32'(in_ready), 32'd1);
    end
  endtask

  task automatic chk_reset_outs();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_link", 32'(out_link), 32'd0);
    chk("rst_out_dtau", out_dtau, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_stg_link", 32'(stg_link), 32'd0);
    chk("rst_stg_curr_az", stg_curr_AZ, 32'd0);
    chk("rst_stg_minv", 32'(stg_minv), 32'd0);
  endtask

  initial begin
    int dc;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_link = 3'd0;
    in_sinq = '0;
    in_cosq = '0;
    in_f_AX = '0; in_f_AY = '0; in_f_AZ = '0;
    in_f_LX = '0; in_f_LY = '0; in_f_LZ = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outs();
`ifdef DQDBP_PROFILE_EN
    chk("rst_cycles", 32'(cycles_out), 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // plain run
    push_seq();
    load(0, 3'd0);
    wait_done();

    // output stall right after RUN entry
    @(posedge clk); #1;
    push_seq();
    load(0, 3'd0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_link", 32'(out_link), 32'd7);
      chk("stall_dtau", out_dtau, 32'h0007_0000);
      chk("stall_k", 32'(stg_link), 32'd6);
    end
    out_ready = 1'b1;
    wait_done();
`ifdef DQDBP_PROFILE_EN
    chk("profile_cycles", 32'(cycles_out), 32'd10);
`endif

    // reset in the middle of the walk
    @(posedge clk); #1;
    dc = done_cnt;
    push_seq();
    load(0, 3'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_k", 32'(stg_link), 32'd4);
    rst_n = 1'b0;
    #1;
    chk_reset_outs();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt), 32'(dc));
    @(posedge clk); #1;
    push_seq();
    load(0, 3'd0);
    wait_done();

    // out-of-order load beat
    @(posedge clk); #1;
    load(2, 3'd3);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("err_pulse_end", 32'(load_err), 32'd0);
      chk("err_no_valid", 32'(out_valid), 32'd0);
      chk("err_idle_ready", 32'(in_ready), 32'd1);
    end
    push_seq();
    load(0, 3'd0);
    wait_done();

    // in_valid held high with junk during the walk
    @(posedge clk); #1;
    push_seq();
    load(0, 3'd0);
    in_valid = 1'b1;
    in_link  = 3'd1;
    in_f_AZ  = 32'hDEAD_BEEF;
    in_f_AX  = 32'h1234_5678;
    for (int i = 0; i < 7; i++) begin
      chk("run_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_f_AX  = '0;
    wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1);
  end

endmodule
